// File: rtl/seq_borrow_subtractor_if.sv
// Operand/result bundle for the sequential borrow subtractor.
// The master drives the request and operands; the slave returns status and the registered result.
interface seq_borrow_subtractor_if;
    logic       start;
    logic [7:0] din_a;
    logic [7:0] din_b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       overflow;

    modport master (
        output start, din_a, din_b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, din_a, din_b, bin,
        output busy, done, diff, bout, overflow
    );
endinterface

// File: rtl/seq_borrow_subtractor.sv
// 8-bit subtractor that resolves two bits per cycle through a rippled borrow.
// Latency: 4 CALC cycles then a 1-cycle DONE; no backpressure, start is ignored unless IDLE.
module seq_borrow_subtractor (
    input  logic                          clk,
    input  logic                          rst,
    seq_borrow_subtractor_if.slave        bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       borrow_q, borrow_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;

    logic [2:0] sel;
    logic [2:0] slice_res;
    logic [7:0] diff_full;

    // Bit 2 of the 3-bit slice result is the borrow out of this slice.
    assign sel       = {idx_q, 1'b0};
    assign slice_res = {1'b0, a_q[sel +: 2]} - {1'b0, b_q[sel +: 2]} - {2'b00, borrow_q};
    assign diff_full = {slice_res[1:0], acc_q[5:0]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.din_a;
                    b_d      = bus.din_b;
                    borrow_d = bus.bin;
                    idx_d    = 2'd0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d[sel +: 2] = slice_res[1:0];
                borrow_d        = slice_res[2];
                idx_d           = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    diff_d  = diff_full;
                    bout_d  = slice_res[2];
                    ovf_d   = (a_q[7] != b_q[7]) && (diff_full[7] != a_q[7]);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            borrow_q <= 1'b0;
            acc_q    <= 8'h00;
            diff_q   <= 8'h00;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == CALC);
    assign bus.done     = (state_q == DONE);
    assign bus.diff     = diff_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// Directed and randomized checks of the sequential borrow subtractor.
module tb_seq_borrow_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   ops_done = 0;

    seq_borrow_subtractor_if dif();

    seq_borrow_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dif.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one operation at the next negedge (also releasing rst) and checks timing and result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] e_diff, input logic e_bout, input logic e_ovf);
        int cycles;
        @(negedge clk);
        rst       = 1'b0;
        dif.start = 1'b1;
        dif.din_a = a;
        dif.din_b = b;
        dif.bin   = bi;
        @(posedge clk); #1;
        check("busy_after_accept", dif.busy, 1);
        @(negedge clk);
        dif.start = 1'b0;
        cycles = 0;
        while (dif.done !== 1'b1 && cycles < 10) begin
            if (cycles < 3) check("busy_in_calc", dif.busy, 1);
            @(posedge clk); #1;
            cycles++;
        end
        check("done_latency", cycles, 4);
        check("busy_in_done", dif.busy, 0);
        check("diff", dif.diff, e_diff);
        check("bout", dif.bout, e_bout);
        check("overflow", dif.overflow, e_ovf);
        ops_done++;
        @(posedge clk); #1;
        check("done_one_cycle", dif.done, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] full;
        int         pre;

        rst = 1'b1;
        dif.start = 1'b0;
        dif.din_a = 8'h00;
        dif.din_b = 8'h00;
        dif.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", dif.busy, 0);
        check("rst_done", dif.done, 0);
        check("rst_diff", dif.diff, 8'h00);
        check("rst_bout", dif.bout, 0);
        check("rst_ovf", dif.overflow, 0);

        // Start coinciding with reset must not be accepted or queued.
        @(negedge clk);
        dif.start = 1'b1;
        dif.din_a = 8'h33;
        @(posedge clk); #1;
        check("rst_start_prio", dif.busy, 0);
        @(negedge clk);
        dif.start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_noqueue", dif.busy, 0);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("hold_diff", dif.diff, 8'h80);
        check("hold_bout", dif.bout, 1);

        // Early second request and mid-CALC operand changes are ignored; old result held during CALC.
        pre = done_cnt;
        @(negedge clk);
        dif.start = 1'b1;
        dif.din_a = 8'h5A;
        dif.din_b = 8'h3C;
        dif.bin   = 1'b0;
        @(posedge clk); #1;
        check("early_busy", dif.busy, 1);
        check("diff_not_cleared", dif.diff, 8'h80);
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        dif.start = 1'b1;
        dif.din_a = 8'hFF;
        dif.din_b = 8'h00;
        dif.bin   = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        dif.din_a = 8'h11;
        repeat (2) @(posedge clk);
        #1;
        check("early_done", dif.done, 1);
        check("early_diff", dif.diff, 8'h1E);
        check("early_bout", dif.bout, 0);
        ops_done++;
        repeat (8) @(posedge clk);
        #1;
        check("early_single_done", done_cnt - pre, 1);

        // Reset on the third CALC cycle aborts the operation silently.
        pre = done_cnt;
        @(negedge clk);
        dif.start = 1'b1;
        dif.din_a = 8'h5A;
        dif.din_b = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", dif.busy, 0);
        check("abort_done", dif.done, 0);
        check("abort_diff", dif.diff, 8'h00);
        check("abort_bout", dif.bout, 0);
        check("abort_no_done", done_cnt - pre, 0);
        run_op(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = i[0];
            case (i % 6)
                0: ra = 8'h00;
                1: rb = 8'hFF;
                2: begin ra = 8'hFF; rb = 8'h00; end
                3: begin ra = 8'h00; rb = 8'hFF; end
                default: ;
            endcase
            full = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
            run_op(ra, rb, rbi, full[7:0], full[8],
                   (ra[7] != rb[7]) && (full[7] != ra[7]));
        end

        repeat (2) @(posedge clk);
        #1;
        check("total_done_pulses", done_cnt, ops_done);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
